// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake between the pipeline MEM
// stage (master) and the load/store unit (slave), including the stall line.
interface mem_access_unit_if #(
  parameter int XLEN = 32,
  parameter int ALEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [ALEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            stall;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a single-port
// synchronous data RAM (one-cycle read latency) plus the memory-mapped LED
// register. Stores answer one cycle after acceptance, loads two cycles after.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses are
// flagged through resp_err instead of being force-aligned).
// MEM_WORDS is expected to be a power of two; the word index wraps by
// dropping the upper address bits.
`ifndef RAM_MEMORY_SIZE
`define RAM_MEMORY_SIZE 1024
`endif
`ifndef MMIO_LED_ADDR
`define MMIO_LED_ADDR 32'hFFFF_FFF0
`endif

module mem_access_unit #(
  parameter int              XLEN      = 32,
  parameter int              ALEN      = 32,
  parameter int              LED_WIDTH = 4,
  parameter int              MEM_WORDS = `RAM_MEMORY_SIZE,
  parameter logic [ALEN-1:0] LED_ADDR  = `MMIO_LED_ADDR,
  localparam int             AW        = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_unit_if.slave     bus,
  output logic                 dmem_en,
  output logic [3:0]           dmem_we,
  output logic [AW-1:0]        dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [LED_WIDTH-1:0] led_out
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_RESP = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic                   accept_s, is_led_s, misalign_s;
  logic [2:0]             funct3_r;
  logic [1:0]             addr_lo_r;
  logic                   is_led_r;
  logic [XLEN-1:0]        load_data_s;
  logic                   resp_valid_r;
  logic [XLEN-1:0]        resp_rdata_r;
  logic [LED_WIDTH-1:0]   led_r;

  function automatic logic [3:0] get_byte_enable(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: get_byte_enable = 4'b0001 << off;
      3'b001, 3'b101: get_byte_enable = off[1] ? 4'b1100 : 4'b0011;
      default:        get_byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000, 3'b100: store_lanes = {(XLEN/8){d[7:0]}};
      3'b001, 3'b101: store_lanes = {(XLEN/16){d[15:0]}};
      default:        store_lanes = d;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [XLEN-1:0] w, input logic [1:0] off);
    get_byte = w[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] get_halfword(input logic [XLEN-1:0] w, input logic sel);
    get_halfword = w[{sel, 4'b0000} +: 16];
  endfunction

  function automatic logic [XLEN-1:0] sign_extend_byte(input logic [7:0] b);
    sign_extend_byte = {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sign_extend_half(input logic [15:0] h);
    sign_extend_half = {{(XLEN-16){h[15]}}, h};
  endfunction

  function automatic logic [XLEN-1:0] zero_extend_byte(input logic [7:0] b);
    zero_extend_byte = {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] zero_extend_half(input logic [15:0] h);
    zero_extend_half = {{(XLEN-16){1'b0}}, h};
  endfunction

  // A request is taken only in IDLE and never while reset is asserted.
  assign accept_s = (state_r == ST_IDLE) && bus.req_valid && !rst;
  assign is_led_s = (bus.req_addr == LED_ADDR);

`ifdef MISALIGN_TRAP_EN
  // Flag half accesses off a 2-byte boundary and word accesses off a 4-byte boundary.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.req_funct3)
      3'b001, 3'b101: misalign_s = bus.req_addr[0];
      3'b010:         misalign_s = (bus.req_addr[1:0] != 2'b00);
      default:        misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // RAM strobe and byte enables are driven in the accept cycle itself.
  assign dmem_en    = accept_s && !is_led_s && !misalign_s;
  assign dmem_we    = (accept_s && bus.req_we && !is_led_s && !misalign_s)
                      ? get_byte_enable(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
  assign dmem_addr  = bus.req_addr[AW+1:2];
  assign dmem_wdata = store_lanes(bus.req_funct3, bus.req_wdata);

  assign bus.req_ready  = !rst && (state_r == ST_IDLE);
  assign bus.stall      = !rst && (((state_r == ST_IDLE) && bus.req_valid) || (state_r == ST_READ));
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign led_out        = led_r;

  // Lane selection and extension of the RAM word (or LED value) seen in READ.
  always_comb begin
    load_data_s = {XLEN{1'b0}};
    if (is_led_r) begin
      load_data_s = {{(XLEN-LED_WIDTH){1'b0}}, led_r};
    end else begin
      case (funct3_r)
        3'b000:  load_data_s = sign_extend_byte(get_byte(dmem_rdata, addr_lo_r));
        3'b001:  load_data_s = sign_extend_half(get_halfword(dmem_rdata, addr_lo_r[1]));
        3'b100:  load_data_s = zero_extend_byte(get_byte(dmem_rdata, addr_lo_r));
        3'b101:  load_data_s = zero_extend_half(get_halfword(dmem_rdata, addr_lo_r[1]));
        default: load_data_s = dmem_rdata;
      endcase
    end
  end

  // Next-state logic: stores and trapped accesses answer next cycle, loads wait for RAM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.req_we || misalign_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, LED write and registered response generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      is_led_r     <= 1'b0;
      led_r        <= {LED_WIDTH{1'b0}};
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            funct3_r  <= bus.req_funct3;
            addr_lo_r <= bus.req_addr[1:0];
            is_led_r  <= is_led_s;
            if (misalign_s || bus.req_we) begin
              resp_valid_r <= 1'b1;
              resp_rdata_r <= {XLEN{1'b0}};
            end
            if (bus.req_we && is_led_s && !misalign_s) begin
              led_r <= bus.req_wdata[LED_WIDTH-1:0];
            end
          end
        end
        ST_READ: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_data_s;
        end
        ST_RESP: resp_valid_r <= 1'b0;
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Error flag follows each accepted request and holds until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_err <= 1'b0;
    end else if (accept_s) begin
      bus.resp_err <= misalign_s;
    end else begin
      bus.resp_err <= bus.resp_err;
    end
  end
`else
  assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a simple
// byte-writable synchronous RAM model. Expected values are hand-computed.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [3:0]  led_out;
  logic [31:0] ram [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32), .ALEN(32)) bus ();

  mem_access_unit #(
    .XLEN(32), .ALEN(32), .LED_WIDTH(4), .MEM_WORDS(1024), .LED_ADDR(32'hFFFF_FFF0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .led_out(led_out)
  );

  // Synchronous RAM: read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_rdata <= ram[dmem_addr];
      for (int b = 0; b < 4; b++) begin
        if (dmem_we[b]) ram[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_en, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd, input logic [9:0] exp_ad);
    drive(1'b1, f3, addr, wd);
    @(negedge clk);
    chk({tag, "_stall_T"}, {31'd0, bus.stall}, 32'd1);
    chk({tag, "_en"}, {31'd0, dmem_en}, {31'd0, exp_en});
    chk({tag, "_we"}, {28'd0, dmem_we}, {28'd0, exp_we});
    if (exp_en) begin
      chk({tag, "_wdata"}, dmem_wdata, exp_wd);
      chk({tag, "_addr"}, {22'd0, dmem_addr}, {22'd0, exp_ad});
    end
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, "_stall_T1"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, "_ready_T1"}, {31'd0, bus.req_ready}, 32'd0);
    step();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic exp_en, input logic [9:0] exp_ad, input logic [31:0] exp_rd);
    drive(1'b0, f3, addr, 32'd0);
    @(negedge clk);
    chk({tag, "_stall_T"}, {31'd0, bus.stall}, 32'd1);
    chk({tag, "_ready_T"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_en"}, {31'd0, dmem_en}, {31'd0, exp_en});
    chk({tag, "_we"}, {28'd0, dmem_we}, 32'd0);
    if (exp_en) chk({tag, "_addr"}, {22'd0, dmem_addr}, {22'd0, exp_ad});
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_stall_T1"}, {31'd0, bus.stall}, 32'd1);
    chk({tag, "_resp_valid_T1"}, {31'd0, bus.resp_valid}, 32'd0);
    step();
    @(negedge clk);
    chk({tag, "_resp_valid_T2"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, "_resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, "_stall_T2"}, {31'd0, bus.stall}, 32'd0);
    step();
    @(negedge clk);
    chk({tag, "_resp_valid_T3"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_rdata_hold"}, bus.resp_rdata, exp_rd);
    chk({tag, "_ready_T3"}, {31'd0, bus.req_ready}, 32'd1);
    step();
  endtask

  initial begin
    // Reset with a store pending on the bus: nothing may be strobed.
    rst = 1'b1;
    drive(1'b1, 3'b010, 32'h0000_0100, 32'h1111_1111);
    step();
    step();
    @(negedge clk);
    chk("rst_dmem_en", {31'd0, dmem_en}, 32'd0);
    chk("rst_dmem_we", {28'd0, dmem_we}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_led", {28'd0, led_out}, 32'd0);
    step();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);
    step();

    // Word store, then signed / unsigned byte loads of the top byte.
    do_store("sw_100", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF, 10'h040);
    do_load("lb_103", 3'b000, 32'h0000_0103, 1'b1, 10'h040, 32'hFFFF_FFDE);
    do_load("lbu_103", 3'b100, 32'h0000_0103, 1'b1, 10'h040, 32'h0000_00DE);

    // Halfword and byte stores: lane replication and byte enables.
    do_store("sh_102", 3'b001, 32'h0000_0102, 32'hABCD_1234, 1'b1, 4'b1100, 32'h1234_1234, 10'h040);
    do_load("lh_102", 3'b001, 32'h0000_0102, 1'b1, 10'h040, 32'h0000_1234);
    do_load("lh_100", 3'b001, 32'h0000_0100, 1'b1, 10'h040, 32'hFFFF_BEEF);
    do_load("lhu_100", 3'b101, 32'h0000_0100, 1'b1, 10'h040, 32'h0000_BEEF);
    do_store("sb_101", 3'b000, 32'h0000_0101, 32'hFFFF_FF5A, 1'b1, 4'b0010, 32'h5A5A_5A5A, 10'h040);
    do_load("lw_100", 3'b010, 32'h0000_0100, 1'b1, 10'h040, 32'h1234_5AEF);
    do_load("lb_101", 3'b000, 32'h0000_0101, 1'b1, 10'h040, 32'h0000_005A);

    // Word index wraps modulo the RAM depth.
    do_load("lw_wrap", 3'b010, 32'h0000_1100, 1'b1, 10'h040, 32'h1234_5AEF);

    // LED register: no RAM strobe on store or load.
    do_store("sw_led", 3'b010, 32'hFFFF_FFF0, 32'h0000_000A, 1'b0, 4'b0000, 32'd0, 10'd0);
    chk("led_after_store", {28'd0, led_out}, 32'h0000_000A);
    do_load("lw_led", 3'b010, 32'hFFFF_FFF0, 1'b0, 10'd0, 32'h0000_000A);

    // Misaligned word access.
`ifdef MISALIGN_TRAP_EN
    drive(1'b0, 3'b010, 32'h0000_0101, 32'd0);
    @(negedge clk);
    chk("mis_en", {31'd0, dmem_en}, 32'd0);
    chk("mis_stall_T", {31'd0, bus.stall}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mis_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_resp_err", {31'd0, bus.resp_err}, 32'd1);
    chk("mis_resp_rdata", bus.resp_rdata, 32'd0);
    chk("mis_stall_T1", {31'd0, bus.stall}, 32'd0);
    step();
    @(negedge clk);
    chk("mis_resp_valid_T2", {31'd0, bus.resp_valid}, 32'd0);
    chk("mis_ready_T2", {31'd0, bus.req_ready}, 32'd1);
    step();
`else
    do_load("lw_101_aligned", 3'b010, 32'h0000_0101, 1'b1, 10'h040, 32'h1234_5AEF);
    do_load("lh_103_aligned", 3'b001, 32'h0000_0103, 1'b1, 10'h040, 32'h0000_1234);
`endif

    // Reset while a load sits in READ: it is dropped and the LED clears.
    drive(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    chk("rr_en", {31'd0, dmem_en}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_stall_in_rst", {31'd0, bus.stall}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rr_led", {28'd0, led_out}, 32'd0);
    chk("rr_stall", {31'd0, bus.stall}, 32'd0);
    chk("rr_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rr_rdata", bus.resp_rdata, 32'd0);
    step();
    @(negedge clk);
    chk("rr_resp_valid_later", {31'd0, bus.resp_valid}, 32'd0);
    step();

    // req_valid held across a load then a store: stall 1,1,0,1,0.
    drive(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    chk("bb_stall0", {31'd0, bus.stall}, 32'd1);
    chk("bb_ready0", {31'd0, bus.req_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("bb_stall1", {31'd0, bus.stall}, 32'd1);
    chk("bb_ready1", {31'd0, bus.req_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("bb_stall2", {31'd0, bus.stall}, 32'd0);
    chk("bb_ready2", {31'd0, bus.req_ready}, 32'd0);
    chk("bb_resp_valid2", {31'd0, bus.resp_valid}, 32'd1);
    chk("bb_rdata2", bus.resp_rdata, 32'h1234_5AEF);
    step();
    drive(1'b1, 3'b010, 32'h0000_0200, 32'h55AA_55AA);
    @(negedge clk);
    chk("bb_stall3", {31'd0, bus.stall}, 32'd1);
    chk("bb_ready3", {31'd0, bus.req_ready}, 32'd1);
    chk("bb_we3", {28'd0, dmem_we}, 32'h0000_000F);
    chk("bb_addr3", {22'd0, dmem_addr}, 32'h0000_0080);
    step();
    @(negedge clk);
    chk("bb_stall4", {31'd0, bus.stall}, 32'd0);
    chk("bb_ready4", {31'd0, bus.req_ready}, 32'd0);
    chk("bb_resp_valid4", {31'd0, bus.resp_valid}, 32'd1);
    chk("bb_rdata4", bus.resp_rdata, 32'd0);
    step();
    bus.req_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
